// File: rtl/ahb_sram_pkg.sv
// Shared encodings, FSM state type and byte-lane helpers for the AHB wait-state SRAM.
package ahb_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [2:0] {IDLE, WAIT, LAST, ERR1, ERR2} state_t;

  // Byte lanes touched by a transfer: (2^size) ones shifted up to the lane offset.
  function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] addr_lsbs);
    logic [15:0] mask;
    mask = ((16'd1 << (16'd1 << size)) - 16'd1) << addr_lsbs;
    return mask[7:0];
  endfunction

  // Low address bits that must be zero for a naturally aligned transfer of this size.
  function automatic logic [2:0] align_mask(input logic [2:0] size);
    logic [2:0] mask;
    case (size)
      HSIZE_BYTE:  mask = 3'b000;
      HSIZE_HALF:  mask = 3'b001;
      HSIZE_WORD:  mask = 3'b011;
      HSIZE_DWORD: mask = 3'b111;
      default:     mask = 3'b111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/sram_lane_bank.sv
// One byte lane of the SRAM: 8-bit synchronous array with one read and one write port.
// A read and a write to the same entry on the same edge returns the old contents.
module sram_lane_bank #(
  parameter int WORD_BITS = 14
) (
  input  logic                 hclk,
  input  logic                 rd_en,
  input  logic [WORD_BITS-1:0] rd_addr,
  input  logic                 wr_en,
  input  logic [WORD_BITS-1:0] wr_addr,
  input  logic [7:0]           wr_data,
  output logic [7:0]           rd_data
);

  logic [7:0] mem [0:(1<<WORD_BITS)-1];

  // Registered read that holds its value until the next read enable; write on wr_en.
  always_ff @(posedge hclk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ahb_wait_sram.sv
// AHB-Lite slave SRAM with programmable wait states, byte-lane writes,
// read-after-write forwarding and a two-cycle ERROR response for illegal accesses.
// Optional write protection below PROTECT_LIMIT: define AHB_SRAM_WRITE_PROTECT_EN.
// FILE_NO names the simulation preload image; the lane banks here start uninitialised.
module ahb_wait_sram
  import ahb_sram_pkg::*;
#(
  parameter int          DATA_BYTES    = 4,
  parameter int          ADDR_BITS     = 16,
  parameter int          WAIT_STATES   = 0,
  parameter int          FILE_NO       = 0,
  parameter logic [31:0] PROTECT_LIMIT = 32'h0
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic                    hsel,
  input  logic [1:0]              htrans,
  input  logic [31:0]             haddr,
  input  logic [2:0]              hsize,
  input  logic                    hwrite,
  input  logic                    hready,
  input  logic [8*DATA_BYTES-1:0] hwdata,
  output logic [8*DATA_BYTES-1:0] hrdata,
  output logic                    hreadyout,
  output logic                    hresp
);

  localparam int         LOG2_BYTES = (DATA_BYTES == 8) ? 3 : 2;
  localparam int         WORD_BITS  = ADDR_BITS - LOG2_BYTES;
  localparam int         DW         = 8 * DATA_BYTES;
  localparam logic [3:0] WS_LOAD    = 4'(WAIT_STATES);
  localparam logic [2:0] LSB_MASK   = 3'(DATA_BYTES - 1);
  localparam bit         CFG_OK     = (DATA_BYTES == 4 || DATA_BYTES == 8) &&
                                      (WAIT_STATES >= 0 && WAIT_STATES <= 15) &&
                                      (FILE_NO >= 0 && FILE_NO <= 2) &&
                                      (ADDR_BITS > LOG2_BYTES && ADDR_BITS < 32);
`ifdef AHB_SRAM_WRITE_PROTECT_EN
  localparam bit PROTECT_EN = 1'b1;
`else
  localparam bit PROTECT_EN = 1'b0;
`endif

  if (!CFG_OK) begin : g_bad_cfg
    $error("ahb_wait_sram: unsupported parameter combination");
  end

  state_t                 state, state_nxt;
  logic [3:0]             wait_cnt;
  logic                   dp_valid, dp_write;
  logic [WORD_BITS-1:0]   dp_word;
  logic [DATA_BYTES-1:0]  dp_lanes;
  logic [DATA_BYTES-1:0]  fwd_mask;
  logic [DW-1:0]          fwd_data;
  logic [7:0]             bank_q [DATA_BYTES];
  logic [DW-1:0]          merged;

  logic                   accept, illegal, legal_accept, err_accept;
  logic                   addr_bad, size_bad, align_bad, protect_bad;
  logic                   read_en, write_commit, fwd_hit;
  logic [WORD_BITS-1:0]   acc_word;
  logic [2:0]             addr_lsbs;
  logic [DATA_BYTES-1:0]  acc_lanes;

  assign accept       = hsel && hready && (htrans != HTRANS_IDLE) && (htrans != HTRANS_BUSY);
  assign addr_bad     = (haddr >> ADDR_BITS) != 32'd0;
  assign size_bad     = hsize > 3'(LOG2_BYTES);
  assign align_bad    = (haddr[2:0] & align_mask(hsize)) != 3'd0;
  assign protect_bad  = PROTECT_EN && hwrite && (haddr < PROTECT_LIMIT);
  assign illegal      = addr_bad | size_bad | align_bad | protect_bad;
  assign legal_accept = accept & ~illegal;
  assign err_accept   = accept & illegal;

  assign acc_word     = haddr[ADDR_BITS-1:LOG2_BYTES];
  assign addr_lsbs    = haddr[2:0] & LSB_MASK;
  assign acc_lanes    = DATA_BYTES'(lane_mask(hsize, addr_lsbs));

  assign read_en      = hreadyout & legal_accept & ~hwrite;
  assign write_commit = dp_valid & dp_write & hreadyout;
  assign fwd_hit      = write_commit & (dp_word == acc_word);

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: ready states accept new transfers, WAIT counts down, errors take two cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, LAST, ERR2: begin
        if (err_accept) begin
          state_nxt = ERR1;
        end else if (legal_accept && (WAIT_STATES != 0)) begin
          state_nxt = WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (wait_cnt <= 4'd1) begin
          state_nxt = LAST;
        end
      end
      ERR1:    state_nxt = ERR2;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus handshake outputs decoded from the state.
  always_comb begin
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    case (state)
      WAIT: hreadyout = 1'b0;
      ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      ERR2:    hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  // Data-phase context, wait counter and forwarding capture for a read meeting a committing write.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_word  <= '0;
      dp_lanes <= '0;
      wait_cnt <= 4'd0;
      fwd_mask <= '0;
      fwd_data <= '0;
    end else begin
      if (hreadyout) begin
        dp_valid <= legal_accept;
        dp_write <= hwrite;
        dp_word  <= acc_word;
        dp_lanes <= acc_lanes;
        if (read_en) begin
          fwd_mask <= fwd_hit ? dp_lanes : '0;
          fwd_data <= hwdata;
        end
      end
      if (state == WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end else if (hreadyout && legal_accept) begin
        wait_cnt <= WS_LOAD;
      end
    end
  end

  for (genvar i = 0; i < DATA_BYTES; i++) begin : g_lane
    sram_lane_bank #(
      .WORD_BITS(WORD_BITS)
    ) u_bank (
      .hclk    (hclk),
      .rd_en   (read_en),
      .rd_addr (acc_word),
      .wr_en   (write_commit & dp_lanes[i]),
      .wr_addr (dp_word),
      .wr_data (hwdata[8*i +: 8]),
      .rd_data (bank_q[i])
    );
    assign merged[8*i +: 8] = fwd_mask[i] ? fwd_data[8*i +: 8] : bank_q[i];
  end

  assign hrdata = (dp_valid && !dp_write && hreadyout) ? merged : '0;

endmodule

// File: tb/tb_ahb_wait_sram.sv
// Directed bench for ahb_wait_sram: one zero-wait and one three-wait instance,
// plus a write-protected instance when AHB_SRAM_WRITE_PROTECT_EN is defined.
module tb_ahb_wait_sram;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;

  logic        sel_a, sel_b;
  logic [31:0] rdata_a, rdata_b;
  logic        ready_a, ready_b, resp_a, resp_b;

  int          cur;
  logic [31:0] obs_rdata;
  logic        obs_ready, obs_resp;
  int          total = 0;
  int          bad = 0;
  int          low;

  always #5 hclk = ~hclk;

  ahb_wait_sram #(.DATA_BYTES(4), .ADDR_BITS(16), .WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(sel_a), .htrans(htrans), .haddr(haddr),
    .hsize(hsize), .hwrite(hwrite), .hready(ready_a), .hwdata(hwdata),
    .hrdata(rdata_a), .hreadyout(ready_a), .hresp(resp_a));

  ahb_wait_sram #(.DATA_BYTES(4), .ADDR_BITS(16), .WAIT_STATES(3)) u_ws3 (
    .hclk(hclk), .hresetn(hresetn), .hsel(sel_b), .htrans(htrans), .haddr(haddr),
    .hsize(hsize), .hwrite(hwrite), .hready(ready_b), .hwdata(hwdata),
    .hrdata(rdata_b), .hreadyout(ready_b), .hresp(resp_b));

`ifdef AHB_SRAM_WRITE_PROTECT_EN
  logic        sel_p;
  logic [31:0] rdata_p;
  logic        ready_p, resp_p;

  ahb_wait_sram #(.DATA_BYTES(4), .ADDR_BITS(16), .WAIT_STATES(0),
                  .PROTECT_LIMIT(32'h0000_1000)) u_prot (
    .hclk(hclk), .hresetn(hresetn), .hsel(sel_p), .htrans(htrans), .haddr(haddr),
    .hsize(hsize), .hwrite(hwrite), .hready(ready_p), .hwdata(hwdata),
    .hrdata(rdata_p), .hreadyout(ready_p), .hresp(resp_p));
`endif

  // Route the outputs of the instance under test to one set of observation signals.
  always_comb begin
    obs_rdata = rdata_a;
    obs_ready = ready_a;
    obs_resp  = resp_a;
    if (cur == 1) begin
      obs_rdata = rdata_b;
      obs_ready = ready_b;
      obs_resp  = resp_b;
    end
`ifdef AHB_SRAM_WRITE_PROTECT_EN
    if (cur == 2) begin
      obs_rdata = rdata_p;
      obs_ready = ready_p;
      obs_resp  = resp_p;
    end
`endif
  end

  // Drive one bus cycle to the selected instance, then step to just after the edge.
  task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                               input logic [2:0] size, input logic write, input logic [31:0] wdata);
    sel_a  = sel && (cur == 0);
    sel_b  = sel && (cur == 1);
`ifdef AHB_SRAM_WRITE_PROTECT_EN
    sel_p  = sel && (cur == 2);
`endif
    htrans = trans;
    haddr  = addr;
    hsize  = size;
    hwrite = write;
    hwdata = wdata;
    @(posedge hclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Idle the bus while hreadyout is low, counting stall cycles (bounded).
  task automatic waitReady(input logic [31:0] wdata, output int stalls);
    stalls = 0;
    while (!obs_ready && stalls < 32) begin
      applyStimulus(1'b0, 2'b00, 32'h0, 3'd0, 1'b0, wdata);
      stalls++;
    end
  endtask

  initial begin
    $display("[TB] start");
    cur = 1;
    sel_a = 0; sel_b = 0;
`ifdef AHB_SRAM_WRITE_PROTECT_EN
    sel_p = 0;
`endif
    htrans = 0; haddr = 0; hsize = 0; hwrite = 0; hwdata = 0;
    hresetn = 1'b0;
    repeat (3) @(posedge hclk);
    #1;
    checkOutput("rst_ready", obs_ready, 1);
    checkOutput("rst_resp", obs_resp, 0);
    checkOutput("rst_rdata", obs_rdata, 0);
    hresetn = 1'b1;

    // Three wait states: word write then read back, both with three stall cycles.
    applyStimulus(1, 2'b10, 32'h100, 3'd2, 1, 32'h0);
    waitReady(32'hDEADBEEF, low);
    checkOutput("ws3_wr_stalls", low, 3);
    applyStimulus(1, 2'b10, 32'h100, 3'd2, 0, 32'hDEADBEEF);
    waitReady(32'h0, low);
    checkOutput("ws3_rd_stalls", low, 3);
    checkOutput("ws3_rd_data", obs_rdata, 32'hDEADBEEF);
    checkOutput("ws3_rd_resp", obs_resp, 0);
    applyStimulus(1, 2'b10, 32'h100, 3'd2, 0, 32'h0);
    waitReady(32'h0, low);
    checkOutput("ws3_rd2_data", obs_rdata, 32'hDEADBEEF);
    applyStimulus(0, 2'b00, 32'h0, 3'd0, 0, 32'h0);
    checkOutput("ws3_idle_rdata", obs_rdata, 0);

    // Reset in the middle of a write: old contents must survive.
    applyStimulus(1, 2'b10, 32'h300, 3'd2, 1, 32'h0);
    waitReady(32'h12345678, low);
    applyStimulus(0, 2'b00, 32'h0, 3'd0, 0, 32'h12345678);
    applyStimulus(1, 2'b10, 32'h300, 3'd2, 1, 32'h0);
    applyStimulus(0, 2'b00, 32'h0, 3'd0, 0, 32'hCAFEF00D);
    checkOutput("ws3_wr_in_wait", obs_ready, 0);
    hresetn = 1'b0;
    #1;
    checkOutput("mid_rst_ready", obs_ready, 1);
    checkOutput("mid_rst_resp", obs_resp, 0);
    checkOutput("mid_rst_rdata", obs_rdata, 0);
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
    applyStimulus(1, 2'b10, 32'h300, 3'd2, 0, 32'h0);
    waitReady(32'h0, low);
    checkOutput("ws3_rst_keep", obs_rdata, 32'h12345678);
    applyStimulus(0, 2'b00, 32'h0, 3'd0, 0, 32'h0);

    // Zero wait states: back-to-back word write, byte write, forwarded read.
    cur = 0;
    applyStimulus(1, 2'b10, 32'h100, 3'd2, 1, 32'h0);
    checkOutput("ws0_nowait", obs_ready, 1);
    applyStimulus(1, 2'b10, 32'h103, 3'd0, 1, 32'h11223344);
    checkOutput("ws0_b2b_ready", obs_ready, 1);
    applyStimulus(1, 2'b10, 32'h100, 3'd2, 0, 32'hAA000000);
    checkOutput("ws0_byte_fwd", obs_rdata, 32'hAA223344);
    applyStimulus(1, 2'b11, 32'h100, 3'd2, 0, 32'h0);
    checkOutput("ws0_byte_arr", obs_rdata, 32'hAA223344);
    applyStimulus(0, 2'b00, 32'h0, 3'd0, 0, 32'h0);
    checkOutput("ws0_idle_rdata", obs_rdata, 0);

    // Half-word write to the upper half, read of the same word on the commit edge.
    applyStimulus(1, 2'b10, 32'h200, 3'd2, 1, 32'h0);
    applyStimulus(1, 2'b10, 32'h202, 3'd1, 1, 32'h99887766);
    applyStimulus(1, 2'b10, 32'h200, 3'd2, 0, 32'h5566ABCD);
    checkOutput("ws0_half_fwd", obs_rdata, 32'h55667766);
    applyStimulus(1, 2'b10, 32'h200, 3'd2, 0, 32'h0);
    checkOutput("ws0_half_arr", obs_rdata, 32'h55667766);
    applyStimulus(0, 2'b00, 32'h0, 3'd0, 0, 32'h0);

    // Out-of-range read: two-cycle ERROR.
    applyStimulus(1, 2'b10, 32'h0001_0000, 3'd2, 0, 32'h0);
    checkOutput("range_e1_ready", obs_ready, 0);
    checkOutput("range_e1_resp", obs_resp, 1);
    applyStimulus(0, 2'b00, 32'h0, 3'd0, 0, 32'h0);
    checkOutput("range_e2_ready", obs_ready, 1);
    checkOutput("range_e2_resp", obs_resp, 1);
    applyStimulus(0, 2'b00, 32'h0, 3'd0, 0, 32'h0);
    checkOutput("range_after_resp", obs_resp, 0);

    // Misaligned word write: ERROR and memory untouched.
    applyStimulus(1, 2'b10, 32'h102, 3'd2, 1, 32'h0);
    checkOutput("align_e1_ready", obs_ready, 0);
    checkOutput("align_e1_resp", obs_resp, 1);
    applyStimulus(0, 2'b00, 32'h0, 3'd0, 0, 32'hFFFFFFFF);
    checkOutput("align_e2_resp", obs_resp, 1);
    applyStimulus(1, 2'b10, 32'h100, 3'd2, 0, 32'hFFFFFFFF);
    checkOutput("align_mem_keep", obs_rdata, 32'hAA223344);
    checkOutput("align_rd_resp", obs_resp, 0);

    // Doubleword on a 4-byte bus is oversize.
    applyStimulus(1, 2'b10, 32'h108, 3'd3, 0, 32'h0);
    checkOutput("size_e1_resp", obs_resp, 1);
    applyStimulus(0, 2'b00, 32'h0, 3'd0, 0, 32'h0);
    applyStimulus(0, 2'b00, 32'h0, 3'd0, 0, 32'h0);

`ifdef AHB_SRAM_WRITE_PROTECT_EN
    // Protected region rejects writes but still serves reads.
    cur = 2;
    applyStimulus(1, 2'b10, 32'h0800, 3'd2, 1, 32'h0);
    checkOutput("prot_e1_ready", obs_ready, 0);
    checkOutput("prot_e1_resp", obs_resp, 1);
    applyStimulus(0, 2'b00, 32'h0, 3'd0, 0, 32'h01020304);
    checkOutput("prot_e2_resp", obs_resp, 1);
    applyStimulus(1, 2'b10, 32'h1000, 3'd2, 1, 32'h01020304);
    checkOutput("prot_ok_resp", obs_resp, 0);
    checkOutput("prot_ok_ready", obs_ready, 1);
    applyStimulus(1, 2'b10, 32'h1000, 3'd2, 0, 32'h0BADCAFE);
    checkOutput("prot_ok_data", obs_rdata, 32'h0BADCAFE);
    applyStimulus(1, 2'b10, 32'h0800, 3'd2, 0, 32'h0);
    checkOutput("prot_rd_resp", obs_resp, 0);
    applyStimulus(0, 2'b00, 32'h0, 3'd0, 0, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] time limit");
  end

endmodule
